// File: rtl/bcd_serial_dabble_if.sv
// ============================================================================
// Module      : bcd_serial_dabble_if
// Description : Handshake/result bundle for the serial double-dabble
//               binary-to-BCD converter.
//   start    : master -> slave, request conversion of bin
//   bin      : master -> slave, binary operand (IN_WIDTH bits)
//   busy     : slave -> master, conversion in progress
//   done     : slave -> master, one-cycle pulse, bcd/overflow just updated
//   bcd      : slave -> master, packed BCD result (4*DIGITS bits)
//   overflow : slave -> master, last value exceeded 10^DIGITS-1
//   blank    : slave -> master, leading-zero blanking flags
//              (present only when BCD_DABBLE_BLANK_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_serial_dabble_if #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
);
  logic                  start;
  logic [IN_WIDTH-1:0]   bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;
`ifdef BCD_DABBLE_BLANK_EN
  logic [DIGITS-1:0]     blank;

  modport master (output start, bin, input busy, done, bcd, overflow, blank);
  modport slave  (input start, bin, output busy, done, bcd, overflow, blank);
`else
  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
`endif
endinterface

`default_nettype wire

// File: rtl/bcd_serial_dabble.sv
// ============================================================================
// Module      : bcd_serial_dabble
// Description : Sequential binary-to-BCD converter (shift-and-add-3), one
//               input bit per clock. Conversion latency IN_WIDTH+1 cycles
//               from accepted start to done pulse.
// Ports       :
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : bcd_serial_dabble_if.slave (start/bin in; busy/done/bcd/
//            overflow[/blank] out, all registered)
// Options     : define BCD_DABBLE_BLANK_EN to add the blank output, a
//               leading-zero mask registered alongside bcd.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_dabble #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_dabble_if.slave  bus
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = (IN_WIDTH < 1) ? 1 : $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [IN_WIDTH-1:0]  sr_q,      sr_d;
  logic [SW-1:0]        scr_q,     scr_d;
  logic                 ovs_q,     ovs_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic [SW-1:0]        bcd_q,     bcd_d;
  logic                 ovf_q,     ovf_d;
`ifdef BCD_DABBLE_BLANK_EN
  logic [DIGITS-1:0]    blank_q,   blank_d;
`endif

  logic [SW-1:0]        adj;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    ovs_d   = ovs_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
`ifdef BCD_DABBLE_BLANK_EN
    blank_d = blank_q;
`endif

    // Add-3 correction on every digit in parallel, from pre-shift values.
    adj = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
      end
    end

    case (state_q)
      // DONE accepts start exactly like IDLE so conversions can run back-to-back.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          sr_d    = bus.bin;
          scr_d   = '0;
          ovs_d   = 1'b0;
          cnt_d   = CW'(IN_WIDTH);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        {scr_d, sr_d} = {adj, sr_q} << 1;
        // Any bit pushed out of the top digit means the value did not fit.
        ovs_d = ovs_q | adj[SW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Results are loaded on entry to DONE so they are valid while done=1.
          state_d = S_DONE;
          done_d  = 1'b1;
          bcd_d   = scr_d;
          ovf_d   = ovs_d;
`ifdef BCD_DABBLE_BLANK_EN
          blank_d = '0;
          for (int k = 1; k < DIGITS; k++) begin
            blank_d[k] = ((scr_d >> (4*k)) == '0);
          end
`endif
        end else begin
          busy_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      scr_q   <= '0;
      ovs_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef BCD_DABBLE_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      ovs_q   <= ovs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
`ifdef BCD_DABBLE_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
`ifdef BCD_DABBLE_BLANK_EN
  assign bus.blank    = blank_q;
`endif

endmodule

`default_nettype wire
